// File: rtl/vrf_port_release_unit.sv
// Tracks per-port element beats for each VRF read/write port granted by the allocator
// and emits a one-cycle release pulse once a port has performed all of its beats.
module vrf_port_release_unit #(
    parameter int R_PORTS_NUM = 8,
    parameter int W_PORTS_NUM = 4,
    parameter int LEN_W       = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   alloc_resources_vld_i,
    output logic                   alloc_resources_rdy_o,
    input  logic [R_PORTS_NUM-1:0] r_port_en_i,
    input  logic [W_PORTS_NUM-1:0] w_port_en_i,
    input  logic [LEN_W-1:0]       alloc_len_i,
    input  logic [R_PORTS_NUM-1:0] r_beat_i,
    input  logic [W_PORTS_NUM-1:0] w_beat_i,
    output logic [R_PORTS_NUM-1:0] free_r_port_o,
    output logic [W_PORTS_NUM-1:0] free_w_port_o,
    output logic [R_PORTS_NUM-1:0] r_busy_o,
    output logic [W_PORTS_NUM-1:0] w_busy_o,
    output logic                   err_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_RELEASE = 2'd2
    } port_state_e;

    typedef struct packed {
        port_state_e      state;
        logic [LEN_W-1:0] cnt;
        logic             err;
    } port_next_t;

    port_state_e      r_state_q [R_PORTS_NUM];
    port_state_e      r_state_d [R_PORTS_NUM];
    logic [LEN_W-1:0] r_cnt_q   [R_PORTS_NUM];
    logic [LEN_W-1:0] r_cnt_d   [R_PORTS_NUM];
    port_state_e      w_state_q [W_PORTS_NUM];
    port_state_e      w_state_d [W_PORTS_NUM];
    logic [LEN_W-1:0] w_cnt_q   [W_PORTS_NUM];
    logic [LEN_W-1:0] w_cnt_d   [W_PORTS_NUM];
    logic             err_q;
    logic             err_d;
    logic             accept;

    // Shared next-state rule for one port; accept is only ever asserted for an IDLE port.
    function automatic port_next_t port_step(input port_state_e      st,
                                             input logic [LEN_W-1:0] cnt,
                                             input logic             acc,
                                             input logic             beat,
                                             input logic [LEN_W-1:0] len);
        port_next_t n;
        n.state = st;
        n.cnt   = cnt;
        n.err   = 1'b0;
        case (st)
            ST_IDLE: begin
                n.err = beat;
                if (acc) begin
                    n.cnt   = len;
                    n.state = (len == '0) ? ST_RELEASE : ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (beat) begin
                    n.cnt = cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1)) n.state = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                n.err   = beat;
                n.state = ST_IDLE;
            end
            default: n.state = ST_IDLE;
        endcase
        return n;
    endfunction

    always_comb begin
        alloc_resources_rdy_o = 1'b1;
        for (int i = 0; i < R_PORTS_NUM; i++)
            if (r_port_en_i[i] && (r_state_q[i] != ST_IDLE)) alloc_resources_rdy_o = 1'b0;
        for (int i = 0; i < W_PORTS_NUM; i++)
            if (w_port_en_i[i] && (w_state_q[i] != ST_IDLE)) alloc_resources_rdy_o = 1'b0;
    end

    assign accept = alloc_resources_vld_i & alloc_resources_rdy_o;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        port_next_t nxt;
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        w_state_d = w_state_q;
        w_cnt_d   = w_cnt_q;
        err_d     = err_q;
        for (int i = 0; i < R_PORTS_NUM; i++) begin
            nxt = port_step(r_state_q[i], r_cnt_q[i], accept & r_port_en_i[i], r_beat_i[i],
                            alloc_len_i);
            r_state_d[i] = nxt.state;
            r_cnt_d[i]   = nxt.cnt;
            err_d        = err_d | nxt.err;
        end
        for (int i = 0; i < W_PORTS_NUM; i++) begin
            nxt = port_step(w_state_q[i], w_cnt_q[i], accept & w_port_en_i[i], w_beat_i[i],
                            alloc_len_i);
            w_state_d[i] = nxt.state;
            w_cnt_d[i]   = nxt.cnt;
            err_d        = err_d | nxt.err;
        end
    end

    // NOTE: the counter arrays are reset too; they are small flops, not RAM, and a cleared
    // counter keeps debug views consistent after an aborted allocation.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < R_PORTS_NUM; i++) begin
                r_state_q[i] <= ST_IDLE;
                r_cnt_q[i]   <= '0;
            end
            for (int i = 0; i < W_PORTS_NUM; i++) begin
                w_state_q[i] <= ST_IDLE;
                w_cnt_q[i]   <= '0;
            end
            err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every port samples the same pre-edge state.
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            w_state_q <= w_state_d;
            w_cnt_q   <= w_cnt_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        free_r_port_o = '0;
        r_busy_o      = '0;
        free_w_port_o = '0;
        w_busy_o      = '0;
        for (int i = 0; i < R_PORTS_NUM; i++) begin
            free_r_port_o[i] = (r_state_q[i] == ST_RELEASE);
            r_busy_o[i]      = (r_state_q[i] != ST_IDLE);
        end
        for (int i = 0; i < W_PORTS_NUM; i++) begin
            free_w_port_o[i] = (w_state_q[i] == ST_RELEASE);
            w_busy_o[i]      = (w_state_q[i] != ST_IDLE);
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_vrf_port_release_unit.sv
// Directed self-checking bench for vrf_port_release_unit with the default 8R/4W/16-bit setup.
module tb_vrf_port_release_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        vld;
    logic        rdy;
    logic [7:0]  r_en;
    logic [3:0]  w_en;
    logic [15:0] len;
    logic [7:0]  r_beat;
    logic [3:0]  w_beat;
    logic [7:0]  free_r;
    logic [3:0]  free_w;
    logic [7:0]  r_busy;
    logic [3:0]  w_busy;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    vrf_port_release_unit #(.R_PORTS_NUM(8), .W_PORTS_NUM(4), .LEN_W(16)) dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .alloc_resources_vld_i (vld),
        .alloc_resources_rdy_o (rdy),
        .r_port_en_i           (r_en),
        .w_port_en_i           (w_en),
        .alloc_len_i           (len),
        .r_beat_i              (r_beat),
        .w_beat_i              (w_beat),
        .free_r_port_o         (free_r),
        .free_w_port_o         (free_w),
        .r_busy_o              (r_busy),
        .w_busy_o              (w_busy),
        .err_o                 (err)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; registered outputs are read at that point.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [7:0] r, input logic [3:0] w,
                         input logic [15:0] l);
        vld  = v;
        r_en = r;
        w_en = w;
        len  = l;
        #1;
    endtask

    task automatic idle_inputs();
        vld    = 1'b0;
        r_en   = '0;
        w_en   = '0;
        len    = '0;
        r_beat = '0;
        w_beat = '0;
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle_inputs();
        cyc();
        cyc();
        rstn = 1'b1;
        cyc();
        n_checks++;
        if ({r_busy, w_busy, free_r, free_w} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%h/%h free=%h/%h want all 0",
                     r_busy, w_busy, free_r, free_w);
        end
        n_checks++;
        if ({rdy, err} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_rdy_err: got rdy=%b err=%b want rdy=1 err=0", rdy, err);
        end
    endtask

    task automatic test_basic_release();
        offer(1'b1, 8'h03, 4'h1, 16'd3);
        n_checks++;
        if (rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_rdy: got %b want 1", rdy);
        end
        cyc();
        offer(1'b0, 8'h00, 4'h0, 16'd0);
        r_beat = 8'h03;
        w_beat = 4'h1;
        n_checks++;
        if ({r_busy, w_busy} !== {8'h03, 4'h1}) begin
            n_fail++;
            $display("FAIL basic_busy: got %h/%h want 03/1", r_busy, w_busy);
        end
        for (int k = 0; k < 2; k++) begin
            cyc();
            n_checks++;
            if ({free_r, free_w} !== 12'h0) begin
                n_fail++;
                $display("FAIL basic_early_free beat%0d: got %h/%h want 00/0", k + 1, free_r, free_w);
            end
        end
        cyc();
        idle_inputs();
        n_checks++;
        if ({free_r, free_w} !== {8'h03, 4'h1}) begin
            n_fail++;
            $display("FAIL basic_free: got %h/%h want 03/1", free_r, free_w);
        end
        cyc();
        n_checks++;
        if ({free_r, free_w, r_busy, w_busy} !== 24'h0) begin
            n_fail++;
            $display("FAIL basic_after: got free=%h/%h busy=%h/%h want all 0",
                     free_r, free_w, r_busy, w_busy);
        end
    endtask

    task automatic test_zero_len();
        offer(1'b1, 8'h04, 4'h0, 16'd0);
        cyc();
        idle_inputs();
        n_checks++;
        if ({free_r, r_busy} !== {8'h04, 8'h04}) begin
            n_fail++;
            $display("FAIL zero_len_pulse: got free=%h busy=%h want 04/04", free_r, r_busy);
        end
        cyc();
        n_checks++;
        if ({free_r, r_busy} !== 16'h0) begin
            n_fail++;
            $display("FAIL zero_len_after: got free=%h busy=%h want 00/00", free_r, r_busy);
        end
    endtask

    task automatic test_stall();
        offer(1'b1, 8'h01, 4'h0, 16'd1);
        cyc();
        offer(1'b1, 8'h01, 4'h0, 16'd2);
        r_beat = 8'h01;
        n_checks++;
        if (rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_active_rdy: got %b want 0", rdy);
        end
        cyc();
        r_beat = 8'h00;
        #1;
        n_checks++;
        if ({rdy, free_r} !== {1'b0, 8'h01}) begin
            n_fail++;
            $display("FAIL stall_release: got rdy=%b free=%h want rdy=0 free=01", rdy, free_r);
        end
        cyc();
        n_checks++;
        if ({rdy, r_busy} !== {1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL stall_idle: got rdy=%b busy=%h want rdy=1 busy=00", rdy, r_busy);
        end
        cyc();
        idle_inputs();
        n_checks++;
        if (r_busy !== 8'h01) begin
            n_fail++;
            $display("FAIL stall_accepted: got busy=%h want 01", r_busy);
        end
        r_beat = 8'h01;
        cyc();
        cyc();
        r_beat = 8'h00;
        #1;
        n_checks++;
        if (free_r !== 8'h01) begin
            n_fail++;
            $display("FAIL stall_second_free: got %h want 01", free_r);
        end
        cyc();
    endtask

    task automatic test_staggered();
        offer(1'b1, 8'h10, 4'h0, 16'd2);
        cyc();
        offer(1'b1, 8'h20, 4'h0, 16'd4);
        cyc();
        idle_inputs();
        r_beat = 8'h30;
        cyc();
        cyc();
        r_beat = 8'h20;
        #1;
        n_checks++;
        if (free_r !== 8'h10) begin
            n_fail++;
            $display("FAIL stagger_first: got %h want 10", free_r);
        end
        cyc();
        n_checks++;
        if ({free_r, r_busy} !== {8'h00, 8'h20}) begin
            n_fail++;
            $display("FAIL stagger_gap: got free=%h busy=%h want 00/20", free_r, r_busy);
        end
        cyc();
        r_beat = 8'h00;
        #1;
        n_checks++;
        if (free_r !== 8'h20) begin
            n_fail++;
            $display("FAIL stagger_second: got %h want 20", free_r);
        end
        cyc();
        n_checks++;
        if ({free_r, r_busy, err} !== 17'h0) begin
            n_fail++;
            $display("FAIL stagger_after: got free=%h busy=%h err=%b want 00/00/0",
                     free_r, r_busy, err);
        end
    endtask

    task automatic test_back_to_back();
        offer(1'b1, 8'h00, 4'h0, 16'd7);
        n_checks++;
        if (rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_offer_rdy: got %b want 1", rdy);
        end
        cyc();
        n_checks++;
        if ({r_busy, w_busy} !== 12'h0) begin
            n_fail++;
            $display("FAIL empty_offer_busy: got %h/%h want 00/0", r_busy, w_busy);
        end
        offer(1'b1, 8'h00, 4'h4, 16'd1);
        cyc();
        w_beat = 4'h4;
        cyc();
        w_beat = 4'h0;
        #1;
        n_checks++;
        if ({rdy, free_w} !== {1'b0, 4'h4}) begin
            n_fail++;
            $display("FAIL b2b_release: got rdy=%b free_w=%h want rdy=0 free_w=4", rdy, free_w);
        end
        cyc();
        cyc();
        idle_inputs();
        n_checks++;
        if ({w_busy, free_w} !== {4'h4, 4'h0}) begin
            n_fail++;
            $display("FAIL b2b_realloc: got busy=%h free=%h want 4/0", w_busy, free_w);
        end
        w_beat = 4'h4;
        cyc();
        w_beat = 4'h0;
        #1;
        cyc();
        n_checks++;
        if ({w_busy, err} !== 5'h0) begin
            n_fail++;
            $display("FAIL b2b_done: got busy=%h err=%b want 0/0", w_busy, err);
        end
    endtask

    task automatic test_err_idle_beat();
        offer(1'b1, 8'h40, 4'h0, 16'd2);
        cyc();
        idle_inputs();
        w_beat = 4'h8;
        cyc();
        w_beat = 4'h0;
        #1;
        n_checks++;
        if ({err, r_busy, w_busy} !== {1'b1, 8'h40, 4'h0}) begin
            n_fail++;
            $display("FAIL err_set: got err=%b busy=%h/%h want 1/40/0", err, r_busy, w_busy);
        end
        r_beat = 8'h40;
        cyc();
        n_checks++;
        if (free_r !== 8'h00) begin
            n_fail++;
            $display("FAIL err_counter_kept: got free=%h want 00", free_r);
        end
        cyc();
        r_beat = 8'h00;
        #1;
        n_checks++;
        if ({free_r, err} !== {8'h40, 1'b1}) begin
            n_fail++;
            $display("FAIL err_release: got free=%h err=%b want 40/1", free_r, err);
        end
        cyc();
        cyc();
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b want 1", err);
        end
    endtask

    task automatic test_reset_mid_active();
        offer(1'b1, 8'h00, 4'h2, 16'd5);
        cyc();
        idle_inputs();
        n_checks++;
        if (w_busy !== 4'h2) begin
            n_fail++;
            $display("FAIL rst_mid_setup: got busy=%h want 2", w_busy);
        end
        rstn = 1'b0;
        w_beat = 4'h2;
        cyc();
        w_beat = 4'h0;
        #1;
        n_checks++;
        if ({free_w, w_busy, err} !== 9'h0) begin
            n_fail++;
            $display("FAIL rst_mid_state: got free=%h busy=%h err=%b want 0/0/0",
                     free_w, w_busy, err);
        end
        rstn = 1'b1;
        offer(1'b0, 8'h00, 4'h2, 16'd5);
        n_checks++;
        if (rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_rdy: got %b want 1", rdy);
        end
        for (int k = 0; k < 6; k++) begin
            cyc();
            n_checks++;
            if ({free_w, w_busy} !== 8'h0) begin
                n_fail++;
                $display("FAIL rst_mid_no_pulse cyc%0d: got free=%h busy=%h want 0/0",
                         k, free_w, w_busy);
            end
        end
        idle_inputs();
    endtask

    initial begin
        rstn = 1'b0;
        idle_inputs();
        test_reset();
        test_basic_release();
        test_zero_len();
        test_stall();
        test_staggered();
        test_back_to_back();
        test_err_idle_beat();
        test_reset_mid_active();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
